// File: rtl/cpu_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl_pkg
//   Shared types and constants for the CPU run controller.
//   - run_state_e : controller state encoding (ST_TIMEOUT only exists when
//                   CPU_RUN_CTRL_WATCHDOG_EN is defined)
//   - HALT_INSTR_DEFAULT : instruction word that marks program end
//   - SAT32 : saturation ceiling of the 32-bit counters
//   - state_is_busy / state_is_done : output decode helpers
// Optional feature macro: CPU_RUN_CTRL_WATCHDOG_EN
// -----------------------------------------------------------------------------
package cpu_run_ctrl_pkg;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_000C;
    localparam logic [31:0] SAT32              = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_CPU = 3'd1,
        ST_RUN       = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DONE      = 3'd4
`ifdef CPU_RUN_CTRL_WATCHDOG_EN
        ,
        ST_TIMEOUT   = 3'd5
`endif
    } run_state_e;

    function automatic logic state_is_busy(input run_state_e st);
        return (st == ST_RESET_CPU) || (st == ST_RUN) || (st == ST_DRAIN);
    endfunction

    function automatic logic state_is_done(input run_state_e st);
`ifdef CPU_RUN_CTRL_WATCHDOG_EN
        return (st == ST_DONE) || (st == ST_TIMEOUT);
`else
        return (st == ST_DONE);
`endif
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_counter.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl_counter
//   Saturating 32-bit counter. Counts up (saturating at SAT32) or, with
//   COUNT_DOWN=1, down (saturating at zero).
//   Priority: clr_i > load_i > en_i.
//   Ports:
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     clr_i              force count to zero
//     load_i, load_val_i load an arbitrary start value
//     en_i               advance one step
//     count_o            current count
// -----------------------------------------------------------------------------
module cpu_run_ctrl_counter
    import cpu_run_ctrl_pkg::*;
#(
    parameter bit COUNT_DOWN = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            if (COUNT_DOWN) begin
                if (count_q != '0) count_d = count_q - 32'd1;
            end else begin
                if (count_q != SAT32) count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_run_controller.sv
// -----------------------------------------------------------------------------
// cpu_run_controller
//   Owns one run of the pipelined CPU: accepts a job, holds the CPU in reset
//   while the job parameters are applied, releases it, detects the halt
//   instruction in the fetch stream, drains the pipeline and captures results.
//   Optional feature macro: CPU_RUN_CTRL_WATCHDOG_EN (RUN watchdog -> TIMEOUT).
//   Ports:
//     in_clk, in_rst          clock, asynchronous active-low reset
//     in_start, in_ack        job request (IDLE only), result ack (DONE/TIMEOUT)
//     in_floors/resistance    job parameters, sampled on accepted start
//     in_cpu_*                CPU fetch PC/instruction and result words
//     out_cpu_rst_n           CPU reset, released only in RUN and DRAIN
//     out_init_*              registered job parameters to the CPU
//     out_busy/done/timeout   status
//     out_attempt_count, out_broken_count, out_is_last_broken  captured results
//     out_cycle_count         RUN+DRAIN cycles of the last job (saturating)
//     out_halt_pc             PC at which the halt instruction was fetched
// -----------------------------------------------------------------------------
module cpu_run_controller
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_INSTR   = HALT_INSTR_DEFAULT,
    parameter logic [31:0] MAX_CYCLES   = 32'd100000
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_start,
    input  logic        in_ack,
    input  logic [31:0] in_floors,
    input  logic [31:0] in_resistance,
    input  logic [31:0] in_cpu_pc,
    input  logic [31:0] in_cpu_instruction,
    input  logic [31:0] in_cpu_attempt_count,
    input  logic [31:0] in_cpu_broken_count,
    input  logic        in_cpu_is_last_broken,
    output logic        out_cpu_rst_n,
    output logic [31:0] out_init_floors,
    output logic [31:0] out_init_resistance,
    output logic        out_busy,
    output logic        out_done,
    output logic        out_timeout,
    output logic [31:0] out_attempt_count,
    output logic [31:0] out_broken_count,
    output logic        out_is_last_broken,
    output logic [31:0] out_cycle_count,
    output logic [31:0] out_halt_pc
);

    // Phase timer is loaded with N-1 and the phase ends on the cycle it reads
    // zero, so the phase lasts exactly N cycles.
    localparam logic [31:0] RST_LOAD   = 32'(RST_CYCLES - 1);
    localparam logic [31:0] DRAIN_LOAD = 32'(DRAIN_CYCLES - 1);

    run_state_e  state_q, state_d;
    logic [31:0] floors_q, floors_d;
    logic [31:0] resistance_q, resistance_d;
    logic [31:0] attempt_q, attempt_d;
    logic [31:0] broken_q, broken_d;
    logic        last_broken_q, last_broken_d;
    logic [31:0] halt_pc_q, halt_pc_d;

    logic        cyc_clr;
    logic        cyc_en;
    logic [31:0] cyc_cnt;
    logic        phase_load;
    logic [31:0] phase_load_val;
    logic        phase_en;
    logic [31:0] phase_cnt;
    logic        capture;
    logic        halt_seen;

`ifdef CPU_RUN_CTRL_WATCHDOG_EN
    // Trip on the cycle whose increment makes the counter reach MAX_CYCLES,
    // i.e. after exactly MAX_CYCLES RUN cycles.
    localparam logic [31:0] WD_LAST = (MAX_CYCLES == '0) ? '0 : MAX_CYCLES - 32'd1;
`else
    logic wd_unused;
    assign wd_unused = |MAX_CYCLES;
`endif

    assign halt_seen = (in_cpu_instruction == HALT_INSTR);
    assign cyc_en    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign phase_en  = (state_q == ST_RESET_CPU) || (state_q == ST_DRAIN);

    cpu_run_ctrl_counter #(
        .COUNT_DOWN (1'b0)
    ) u_cycle_cnt (
        .clk_i      (in_clk),
        .rst_ni     (in_rst),
        .clr_i      (cyc_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (cyc_en),
        .count_o    (cyc_cnt)
    );

    cpu_run_ctrl_counter #(
        .COUNT_DOWN (1'b1)
    ) u_phase_cnt (
        .clk_i      (in_clk),
        .rst_ni     (in_rst),
        .clr_i      (1'b0),
        .load_i     (phase_load),
        .load_val_i (phase_load_val),
        .en_i       (phase_en),
        .count_o    (phase_cnt)
    );

    always_comb begin
        state_d        = state_q;
        floors_d       = floors_q;
        resistance_d   = resistance_q;
        attempt_d      = attempt_q;
        broken_d       = broken_q;
        last_broken_d  = last_broken_q;
        halt_pc_d      = halt_pc_q;
        cyc_clr        = 1'b0;
        phase_load     = 1'b0;
        phase_load_val = '0;
        capture        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    floors_d       = in_floors;
                    resistance_d   = in_resistance;
                    attempt_d      = '0;
                    broken_d       = '0;
                    last_broken_d  = 1'b0;
                    halt_pc_d      = '0;
                    cyc_clr        = 1'b1;
                    phase_load     = 1'b1;
                    phase_load_val = RST_LOAD;
                    state_d        = ST_RESET_CPU;
                end
            end
            ST_RESET_CPU: begin
                if (phase_cnt == '0) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Halt is checked first so it wins over a same-cycle watchdog.
                if (halt_seen) begin
                    halt_pc_d      = in_cpu_pc;
                    phase_load     = 1'b1;
                    phase_load_val = DRAIN_LOAD;
                    state_d        = ST_DRAIN;
                end
`ifdef CPU_RUN_CTRL_WATCHDOG_EN
                else if (cyc_cnt >= WD_LAST) begin
                    capture = 1'b1;
                    state_d = ST_TIMEOUT;
                end
`endif
            end
            ST_DRAIN: begin
                if (phase_cnt == '0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (in_ack) state_d = ST_IDLE;
            end
`ifdef CPU_RUN_CTRL_WATCHDOG_EN
            ST_TIMEOUT: begin
                if (in_ack) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            attempt_d     = in_cpu_attempt_count;
            broken_d      = in_cpu_broken_count;
            last_broken_d = in_cpu_is_last_broken;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q       <= ST_IDLE;
            floors_q      <= '0;
            resistance_q  <= '0;
            attempt_q     <= '0;
            broken_q      <= '0;
            last_broken_q <= 1'b0;
            halt_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            floors_q      <= floors_d;
            resistance_q  <= resistance_d;
            attempt_q     <= attempt_d;
            broken_q      <= broken_d;
            last_broken_q <= last_broken_d;
            halt_pc_q     <= halt_pc_d;
        end
    end

    assign out_cpu_rst_n       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign out_busy            = state_is_busy(state_q);
    assign out_done            = state_is_done(state_q);
`ifdef CPU_RUN_CTRL_WATCHDOG_EN
    assign out_timeout         = (state_q == ST_TIMEOUT);
`else
    assign out_timeout         = 1'b0;
`endif
    assign out_init_floors     = floors_q;
    assign out_init_resistance = resistance_q;
    assign out_attempt_count   = attempt_q;
    assign out_broken_count    = broken_q;
    assign out_is_last_broken  = last_broken_q;
    assign out_cycle_count     = cyc_cnt;
    assign out_halt_pc         = halt_pc_q;

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Sequencer that owns one run of the five-stage pipelined CPU: it accepts a job (floors, resistance) from a host, holds the CPU in reset while it applies the job parameters, then releases the CPU. It then detects program completion from the fetch stream, drains the pipeline, and captures the three result words. It sits between the host/testbench and the CPU top level, driving the CPU's reset and init inputs and observing its PC, instruction and result outputs.

## Interface
- RST_CYCLES, 4: cycles the CPU reset is held after a start.
- DRAIN_CYCLES, 4: cycles waited after halt detection so in-flight instructions reach WB.
- HALT_INSTR, 32'h0000_000C: fetched instruction word that marks program end.
- MAX_CYCLES, 32'd100000: watchdog limit on cycles spent in RUN (used only with the watchdog macro).
- in_clk  in  1  clock.
- in_rst  in  1  reset; one clock, asynchronous assert, active-low.
- in_start  in  1  single-cycle job request; honoured only in IDLE.
- in_ack  in  1  host acknowledges results; honoured only in DONE/TIMEOUT.
- in_floors  in  32  job floors; sampled on accepted start.
- in_resistance  in  32  job resistance; sampled on accepted start.
- in_cpu_pc  in  32  CPU fetch PC.
- in_cpu_instruction  in  32  CPU fetched instruction.
- in_cpu_attempt_count  in  32  CPU result.
- in_cpu_broken_count  in  32  CPU result.
- in_cpu_is_last_broken  in  1  CPU result.
- out_cpu_rst_n  out  1  CPU reset, active-low; low in every state except RUN and DRAIN.
- out_init_floors  out  32  registered job floors to the CPU.
- out_init_resistance  out  32  registered job resistance to the CPU.
- out_busy  out  1  high in RESET_CPU, RUN, DRAIN.
- out_done  out  1  high in DONE and TIMEOUT.
- out_timeout  out  1  high in TIMEOUT only.
- out_attempt_count  out  32  captured result.
- out_broken_count  out  32  captured result.
- out_is_last_broken  out  1  captured result.
- out_cycle_count  out  32  cycles spent in RUN+DRAIN for the last job, saturating at 32'hFFFF_FFFF.
- out_halt_pc  out  32  PC at which HALT_INSTR was fetched.

## Operation
- States: IDLE, RESET_CPU, RUN, DRAIN, DONE, and TIMEOUT (TIMEOUT exists only with the watchdog macro).
- IDLE: on in_start=1, latch in_floors/in_resistance into out_init_*, clear the cycle counter and the captured results, and go to RESET_CPU.
- RESET_CPU: hold out_cpu_rst_n=0 for exactly RST_CYCLES cycles, then go to RUN.
- RUN: out_cpu_rst_n=1 and the counter increments every cycle. When in_cpu_instruction==HALT_INSTR, latch in_cpu_pc into out_halt_pc and go to DRAIN.
- DRAIN: the counter keeps incrementing. After DRAIN_CYCLES cycles, capture the three CPU results and go to DONE.
- DONE/TIMEOUT: outputs hold. On in_ack=1, go to IDLE; captured values persist until the next accepted start.
- in_start outside IDLE is ignored. in_ack outside DONE/TIMEOUT is ignored.
- If in_start and in_ack are both high in DONE, the ack is taken and the start is dropped; the host must pulse start again in IDLE.
- out_init_* do not change between accepted starts.

## Timing
- Asynchronous in_rst low forces, in any state including mid-run:
  - state=IDLE, out_cpu_rst_n=0;
  - all data outputs 0, out_busy, out_done and out_timeout 0.
- Start accepted at edge t: out_busy=1 and out_cpu_rst_n=0 from t+1. out_cpu_rst_n rises at t+1+RST_CYCLES.
- Halt fetched in cycle h: DRAIN runs from h+1 to h+DRAIN_CYCLES. Results are sampled at the final DRAIN edge, and out_done=1 in the following cycle.
- Counter: 32-bit, +1 per RUN/DRAIN cycle, saturating with no wrap.
- out_done falls the cycle after in_ack is sampled.

## Configuration
- CPU_RUN_CTRL_WATCHDOG_EN defined:
  - In RUN, when the counter reaches MAX_CYCLES, capture results and go to TIMEOUT (out_done=1, out_timeout=1).
  - If the halt instruction and MAX_CYCLES occur in the same cycle, halt wins and the state goes to DRAIN.
- Undefined: no TIMEOUT state, out_timeout tied 0, and RUN waits indefinitely for the halt instruction.

## Structure
- Shared package cpu_run_ctrl_pkg: the state enum type, the HALT_INSTR default, and the 32-bit saturation constant.
- One sub-module, cpu_run_ctrl_counter: a saturating 32-bit counter with clear and enable inputs, also used for the RST_CYCLES and DRAIN_CYCLES down-counts.

## Test plan
- Basic run: start with floors=100, resistance=20; the CPU model fetches HALT_INSTR at PC 0x40 after 300 RUN cycles.
  - Expect out_cpu_rst_n low for 4 cycles and out_halt_pc=0x40.
  - Expect out_cycle_count=305 (300 RUN cycles, the halt cycle, and 4 DRAIN cycles); results match the model at the end of DRAIN.
- Handshake: pulse in_start during RUN, then in_ack during RUN → both ignored, and init values are unchanged. Later, start and ack together in DONE → IDLE with out_done=0.
- Asynchronous reset mid-DRAIN: assert in_rst low between clock edges → outputs go to 0 immediately and out_cpu_rst_n=0. After release, state is IDLE.
- Watchdog (macro defined, MAX_CYCLES=50), program never halts → TIMEOUT after 50 RUN cycles with out_timeout=1 and out_done=1. With the macro undefined, out_busy stays 1.
- Halt and watchdog in the same cycle → DRAIN is entered and out_timeout=0.
- Back-to-back jobs: the second start after ack loads new floors=7, and the counter restarts from 0.
